priv_trap_ctrl: RTL and testbench

Parametrised successor to the decode-stage control/privilege unit: decodes SYSTEM-class instructions, tracks the current privilege level across M/S/U, arbitrates interrupts against the instruction stream and delegates exceptions. It sits between fetch/decode and execute with a registered valid/ready output stage. Unlike its predecessor, it adds:
- a stall FSM for trap entry and WFI;
- optional S-mode with `sret` and `medeleg` delegation;
- CSR read-only and privilege-field checks;
- a parametrised interrupt vector.

---
 rtl/priv_trap_ctrl.sv | 289 ++++++++++++++++++++++++++++
 tb/tb_priv_trap_ctrl.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/priv_trap_ctrl.sv
// priv_trap_ctrl: SYSTEM-class decode, privilege tracking, interrupt
// arbitration and exception delegation with a registered valid/ready
// output stage and a stall FSM for trap entry and WFI.
module priv_trap_ctrl #(
   parameter int unsigned DATA_WIDTH     = 32,
   parameter int unsigned HAS_S_MODE     = 1,
   parameter int unsigned HAS_U_MODE     = 1,
   parameter int unsigned NUM_IRQ        = 4,
   parameter int unsigned IRQ_CAUSE_BASE = 3
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [6:0]            opcode,
   input  logic [2:0]            funct3,
   input  logic [11:0]           csr_addr,
   input  logic [4:0]            rs1_idx,
   input  logic [DATA_WIDTH-1:0] mstatus,
   input  logic [DATA_WIDTH-1:0] medeleg,
   input  logic [NUM_IRQ-1:0]    irq_pending,
   input  logic [NUM_IRQ-1:0]    irq_enable,
   input  logic                  trap_commit,
   input  logic                  xret_commit,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  is_csr,
   output logic [2:0]            csr_op,
   output logic                  is_mret,
   output logic                  is_sret,
   output logic                  is_wfi,
   output logic                  exception_valid,
   output logic [DATA_WIDTH-1:0] exception_cause,
   output logic [1:0]            trap_target,
   output logic [1:0]            current_privilege
);

   localparam logic [1:0] PRIV_M = 2'b11;
   localparam logic [1:0] PRIV_S = 2'b01;
   localparam logic [1:0] PRIV_U = 2'b00;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
   localparam int unsigned IDXW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
   // Lowest implemented privilege; unimplemented return targets collapse here.
   localparam logic [1:0] PRIV_LOW = (HAS_U_MODE != 0) ? PRIV_U :
                                     ((HAS_S_MODE != 0) ? PRIV_S : PRIV_M);

   typedef enum logic [1:0] {
      ST_RUN,
      ST_TRAP_WAIT,
      ST_WFI
   } state_t;

   state_t state_q, state_d;
   logic [1:0] priv_q;
   logic [1:0] trap_tgt_q;
   logic       last_sret_q;

   logic [NUM_IRQ-1:0] irq_elig;
   logic               irq_glob_en;
   logic               irq_hit;
   logic [7:0]         irq_code;
   logic               irq_take;

   logic            dec_exc;
   logic [3:0]      dec_code;
   logic            dec_csr;
   logic [2:0]      dec_op;
   logic            dec_mret;
   logic            dec_sret;
   logic            dec_wfi;
   logic            csr_writes;
   logic [IDXW-1:0] deleg_idx;

   logic                  nxt_exc;
   logic [DATA_WIDTH-1:0] nxt_cause;
   logic [1:0]            nxt_tgt;
   logic                  nxt_csr;
   logic [2:0]            nxt_op;
   logic                  nxt_mret;
   logic                  nxt_sret;
   logic                  nxt_wfi;

   logic accept;
   logic unused_mstatus;

   assign current_privilege = priv_q;
   assign accept            = in_valid & in_ready;
   assign unused_mstatus    = ^mstatus;

   function automatic logic [1:0] legalize(input logic [1:0] p);
      logic [1:0] r;
      case (p)
         PRIV_M:  r = PRIV_M;
         PRIV_S:  r = (HAS_S_MODE != 0) ? PRIV_S : PRIV_LOW;
         PRIV_U:  r = (HAS_U_MODE != 0) ? PRIV_U : PRIV_LOW;
         default: r = PRIV_LOW;
      endcase
      return r;
   endfunction

   // Interrupt eligibility and lowest-index-wins selection.
   assign irq_elig    = irq_pending & irq_enable;
   assign irq_glob_en = (priv_q != PRIV_M) || mstatus[3];
   assign irq_take    = irq_hit && irq_glob_en;

   // Scan downward so the lowest eligible line is the last one written.
   always_comb begin
      irq_hit  = 1'b0;
      irq_code = '0;
      for (int unsigned i = NUM_IRQ; i > 0; i--) begin
         if (irq_elig[i-1]) begin
            irq_hit  = 1'b1;
            irq_code = 8'(IRQ_CAUSE_BASE + i - 1);
         end
      end
   end

   // Decode SYSTEM instructions and apply privilege / read-only checks.
   always_comb begin
      dec_exc    = 1'b0;
      dec_code   = '0;
      dec_csr    = 1'b0;
      dec_op     = '0;
      dec_mret   = 1'b0;
      dec_sret   = 1'b0;
      dec_wfi    = 1'b0;
      csr_writes = (funct3[1:0] == 2'b01) || (rs1_idx != 5'd0);
      if (opcode == OPC_SYSTEM) begin
         case (funct3)
            3'b000: begin
               case (csr_addr)
                  12'h000: begin
                     dec_exc = 1'b1;
                     case (priv_q)
                        PRIV_U:  dec_code = 4'd8;
                        PRIV_S:  dec_code = 4'd9;
                        default: dec_code = 4'd11;
                     endcase
                  end
                  12'h001: begin
                     dec_exc  = 1'b1;
                     dec_code = 4'd3;
                  end
                  12'h302: begin
                     if (priv_q == PRIV_M) begin
                        dec_mret = 1'b1;
                     end else begin
                        dec_exc  = 1'b1;
                        dec_code = 4'd2;
                     end
                  end
                  12'h102: begin
                     if ((HAS_S_MODE != 0) && (priv_q != PRIV_U)) begin
                        dec_sret = 1'b1;
                     end else begin
                        dec_exc  = 1'b1;
                        dec_code = 4'd2;
                     end
                  end
                  12'h105: dec_wfi = 1'b1;
                  default: begin
                     dec_exc  = 1'b1;
                     dec_code = 4'd2;
                  end
               endcase
            end
            3'b100: begin
               dec_exc  = 1'b1;
               dec_code = 4'd2;
            end
            default: begin
               if (csr_addr[9:8] > priv_q) begin
                  dec_exc  = 1'b1;
                  dec_code = 4'd2;
               end else if ((csr_addr[11:10] == 2'b11) && csr_writes) begin
                  dec_exc  = 1'b1;
                  dec_code = 4'd2;
               end else begin
                  dec_csr = 1'b1;
                  dec_op  = funct3;
               end
            end
         endcase
      end
   end

   assign deleg_idx = IDXW'(dec_code);

   // Merge decode with interrupt override and exception delegation.
   always_comb begin
      nxt_exc   = dec_exc;
      nxt_cause = DATA_WIDTH'(dec_code);
      nxt_tgt   = PRIV_M;
      nxt_csr   = dec_csr;
      nxt_op    = dec_op;
      nxt_mret  = dec_mret;
      nxt_sret  = dec_sret;
      nxt_wfi   = dec_wfi;
      if (dec_exc && (HAS_S_MODE != 0) && (priv_q != PRIV_M) && medeleg[deleg_idx]) begin
         nxt_tgt = PRIV_S;
      end
      if (irq_take) begin
         nxt_exc   = 1'b1;
         nxt_cause = {1'b1, (DATA_WIDTH-1)'(irq_code)};
         nxt_tgt   = PRIV_M;
         nxt_csr   = 1'b0;
         nxt_op    = '0;
         nxt_mret  = 1'b0;
         nxt_sret  = 1'b0;
         nxt_wfi   = 1'b0;
      end
   end

   // Stall FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state_q <= ST_RUN;
      else      state_q <= state_d;
   end

   // Stall FSM next-state and input handshake.
   always_comb begin
      state_d  = state_q;
      in_ready = 1'b0;
      case (state_q)
         ST_RUN: begin
            in_ready = !out_valid || out_ready;
            if (in_valid && in_ready) begin
               if (nxt_exc)      state_d = ST_TRAP_WAIT;
               else if (nxt_wfi) state_d = ST_WFI;
            end
         end
         ST_TRAP_WAIT: begin
            if (trap_commit) state_d = ST_RUN;
         end
         ST_WFI: begin
            if (|irq_elig) state_d = ST_RUN;
         end
         default: state_d = ST_RUN;
      endcase
   end

   // Registered control bundle; holds while downstream stalls.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid       <= 1'b0;
         is_csr          <= 1'b0;
         csr_op          <= '0;
         is_mret         <= 1'b0;
         is_sret         <= 1'b0;
         is_wfi          <= 1'b0;
         exception_valid <= 1'b0;
         exception_cause <= '0;
         trap_target     <= PRIV_M;
      end else if (accept) begin
         out_valid       <= 1'b1;
         is_csr          <= nxt_csr;
         csr_op          <= nxt_op;
         is_mret         <= nxt_mret;
         is_sret         <= nxt_sret;
         is_wfi          <= nxt_wfi;
         exception_valid <= nxt_exc;
         exception_cause <= nxt_cause;
         trap_target     <= nxt_tgt;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

   // Privilege register plus the trap target and xret kind it commits from.
   // The latched copies decouple commit from the output stage, which may
   // already hold a younger bundle when writeback reports the commit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         priv_q      <= PRIV_M;
         trap_tgt_q  <= PRIV_M;
         last_sret_q <= 1'b0;
      end else begin
         if (accept && nxt_exc)               trap_tgt_q  <= nxt_tgt;
         if (accept && (nxt_mret || nxt_sret)) last_sret_q <= nxt_sret;
         if (trap_commit) begin
            priv_q <= trap_tgt_q;
         end else if (xret_commit) begin
            if (last_sret_q) priv_q <= legalize(mstatus[8] ? PRIV_S : PRIV_U);
            else             priv_q <= legalize(mstatus[12:11]);
         end
      end
   end

endmodule

// File: tb/tb_priv_trap_ctrl.sv
// Scoreboard bench for priv_trap_ctrl: directed SYSTEM instructions with
// hand-computed bundles, plus a HAS_S_MODE=0 instance checked directly.
module tb_priv_trap_ctrl;

   localparam logic [6:0] SYS = 7'h73;
   localparam logic [1:0] PM  = 2'b11;
   localparam logic [1:0] PS  = 2'b01;
   localparam logic [1:0] PU  = 2'b00;

   typedef struct packed {
      logic        is_csr;
      logic [2:0]  csr_op;
      logic        mret;
      logic        sret;
      logic        wfi;
      logic        exc;
      logic [31:0] cause;
      logic [1:0]  tgt;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic        in_valid = 1'b0;
   logic [6:0]  opcode = '0;
   logic [2:0]  funct3 = '0;
   logic [11:0] csr_addr = '0;
   logic [4:0]  rs1_idx = '0;
   logic [31:0] mstatus = '0;
   logic [31:0] medeleg = '0;
   logic [3:0]  irq_pending = '0;
   logic [3:0]  irq_enable = '0;
   logic        trap_commit = 1'b0;
   logic        xret_commit = 1'b0;
   logic        out_ready = 1'b1;

   logic        in_ready, out_valid, is_csr, is_mret, is_sret, is_wfi, exception_valid;
   logic [2:0]  csr_op;
   logic [31:0] exception_cause;
   logic [1:0]  trap_target, current_privilege;

   logic        ns_in_ready, ns_out_valid, ns_is_csr, ns_is_mret, ns_is_sret, ns_is_wfi, ns_exc;
   logic [2:0]  ns_csr_op;
   logic [31:0] ns_cause;
   logic [1:0]  ns_target, ns_priv;

   priv_trap_ctrl #(.DATA_WIDTH(32), .HAS_S_MODE(1), .HAS_U_MODE(1), .NUM_IRQ(4), .IRQ_CAUSE_BASE(3)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .opcode(opcode), .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx),
      .mstatus(mstatus), .medeleg(medeleg), .irq_pending(irq_pending), .irq_enable(irq_enable),
      .trap_commit(trap_commit), .xret_commit(xret_commit),
      .out_valid(out_valid), .out_ready(out_ready), .is_csr(is_csr), .csr_op(csr_op),
      .is_mret(is_mret), .is_sret(is_sret), .is_wfi(is_wfi),
      .exception_valid(exception_valid), .exception_cause(exception_cause),
      .trap_target(trap_target), .current_privilege(current_privilege)
   );

   priv_trap_ctrl #(.DATA_WIDTH(32), .HAS_S_MODE(0), .HAS_U_MODE(1), .NUM_IRQ(4), .IRQ_CAUSE_BASE(3)) dut_ns (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(ns_in_ready),
      .opcode(opcode), .funct3(funct3), .csr_addr(csr_addr), .rs1_idx(rs1_idx),
      .mstatus(mstatus), .medeleg(medeleg), .irq_pending(irq_pending), .irq_enable(irq_enable),
      .trap_commit(trap_commit), .xret_commit(xret_commit),
      .out_valid(ns_out_valid), .out_ready(out_ready), .is_csr(ns_is_csr), .csr_op(ns_csr_op),
      .is_mret(ns_is_mret), .is_sret(ns_is_sret), .is_wfi(ns_is_wfi),
      .exception_valid(ns_exc), .exception_cause(ns_cause),
      .trap_target(ns_target), .current_privilege(ns_priv)
   );

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;
   exp_t mon_e, mon_a;

   function automatic exp_t mk(input logic c, input logic [2:0] op, input logic mr, input logic sr,
                               input logic wf, input logic ex, input logic [31:0] cause,
                               input logic [1:0] tgt);
      exp_t e;
      e.is_csr = c;  e.csr_op = op; e.mret = mr; e.sret = sr;
      e.wfi = wf;    e.exc = ex;    e.cause = cause; e.tgt = tgt;
      return e;
   endfunction

   function automatic exp_t ex_t(input logic [31:0] cause, input logic [1:0] tgt);
      return mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, cause, tgt);
   endfunction

   function automatic exp_t plain();
      return mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, PM);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: pop and compare whenever the bundle transfers downstream.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         n_chk++;
         if (sb.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_bundle: got cause 0x%0h expected no bundle", exception_cause);
         end else begin
            mon_e = sb.pop_front();
            mon_a.is_csr = is_csr;   mon_a.csr_op = csr_op;
            mon_a.mret   = is_mret;  mon_a.sret   = is_sret;
            mon_a.wfi    = is_wfi;   mon_a.exc    = exception_valid;
            mon_a.cause  = exception_cause;
            mon_a.tgt    = mon_e.exc ? trap_target : mon_e.tgt;
            if (mon_a !== mon_e) begin
               n_fail++;
               $display("FAIL bundle: got 0x%0h expected 0x%0h", mon_a, mon_e);
            end
         end
      end
   end

   task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic [11:0] ca,
                       input logic [4:0] r1, input exp_t e);
      int n;
      n = 0;
      @(posedge clk); #1;
      opcode = op; funct3 = f3; csr_addr = ca; rs1_idx = r1; in_valid = 1'b1;
      sb.push_back(e);
      @(negedge clk);
      while (!in_ready && n < 20) begin
         n++;
         @(negedge clk);
      end
      if (!in_ready) begin
         n_chk++;
         n_fail++;
         $display("FAIL accept_timeout: got in_ready 0 expected 1 within 20 cycles");
         void'(sb.pop_back());
         in_valid = 1'b0;
      end else begin
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic pulse_trap();
      @(posedge clk); #1 trap_commit = 1'b1;
      @(posedge clk); #1 trap_commit = 1'b0;
   endtask

   task automatic pulse_xret();
      @(posedge clk); #1 xret_commit = 1'b1;
      @(posedge clk); #1 xret_commit = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_priv", 64'(current_privilege), 64'(PM));
      @(negedge clk) rst = 1'b1;
      @(negedge clk);
      check("rst_cause", 64'(exception_cause), 64'd0);
      check("rst_target", 64'(trap_target), 64'(PM));
      check("rst_flags", 64'({is_csr, csr_op, is_mret, is_sret, is_wfi, exception_valid}), 64'd0);
      check("rst_in_ready", 64'(in_ready), 64'd1);

      // ecall in M, stall until trap_commit
      send(SYS, 3'b000, 12'h000, 5'd0, ex_t(32'd11, PM));
      check("trap_wait_ready", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("trap_wait_ready2", 64'(in_ready), 64'd0);
      pulse_trap();
      check("priv_after_m_trap", 64'(current_privilege), 64'(PM));
      check("ready_after_commit", 64'(in_ready), 64'd1);

      // mret with MPP=S, then delegated ecall from S
      mstatus = 32'h0000_0800;
      send(SYS, 3'b000, 12'h302, 5'd0, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      pulse_xret();
      check("priv_after_mret", 64'(current_privilege), 64'(PS));
      medeleg = 32'h0000_0204;
      send(SYS, 3'b000, 12'h000, 5'd0, ex_t(32'd9, PS));
      check("s_trap_wait_ready", 64'(in_ready), 64'd0);
      pulse_trap();
      check("priv_after_s_trap", 64'(current_privilege), 64'(PS));

      // CSR checks from S
      send(SYS, 3'b010, 12'h300, 5'd0, ex_t(32'd2, PS));
      pulse_trap();
      send(SYS, 3'b010, 12'hC00, 5'd0, mk(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      send(SYS, 3'b010, 12'hC00, 5'd1, ex_t(32'd2, PS));
      pulse_trap();
      send(SYS, 3'b001, 12'h100, 5'd5, mk(1'b1, 3'b001, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      send(SYS, 3'b101, 12'hC01, 5'd0, ex_t(32'd2, PS));
      pulse_trap();
      send(7'h33, 3'b000, 12'h000, 5'd0, plain());
      send(SYS, 3'b100, 12'h000, 5'd0, ex_t(32'd2, PS));
      pulse_trap();
      send(SYS, 3'b000, 12'h302, 5'd0, ex_t(32'd2, PS));
      pulse_trap();
      check("priv_still_s", 64'(current_privilege), 64'(PS));

      // ebreak not delegated -> back to M
      send(SYS, 3'b000, 12'h001, 5'd0, ex_t(32'd3, PM));
      pulse_trap();
      check("priv_after_ebreak", 64'(current_privilege), 64'(PM));

      // wfi woken by irq[1] with MIE=1
      mstatus = 32'h0000_0808;
      send(SYS, 3'b000, 12'h105, 5'd0, mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, PM));
      check("wfi_stall", 64'(in_ready), 64'd0);
      @(negedge clk);
      check("wfi_stall2", 64'(in_ready), 64'd0);
      @(posedge clk); #1;
      irq_pending = 4'b0110; irq_enable = 4'b1111;
      send(7'h13, 3'b000, 12'h000, 5'd0, ex_t(32'h8000_0004, PM));
      check("irq_trap_wait", 64'(in_ready), 64'd0);
      irq_pending = 4'b0000;
      pulse_trap();

      // M-mode irq with MIE=0 is not taken
      mstatus = 32'h0000_0800;
      irq_pending = 4'b0001; irq_enable = 4'b0001;
      send(7'h13, 3'b000, 12'h000, 5'd0, plain());
      check("masked_irq_ready", 64'(in_ready), 64'd1);

      // wfi still wakes on a masked irq; the next slot is the instruction
      irq_pending = 4'b0000;
      send(SYS, 3'b000, 12'h105, 5'd0, mk(1'b0, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0, PM));
      @(posedge clk); #1 irq_pending = 4'b0001;
      send(7'h13, 3'b000, 12'h000, 5'd0, plain());
      irq_pending = 4'b0000;

      // lowest eligible line wins and replaces the ecall
      mstatus = 32'h0000_0808;
      irq_pending = 4'b1100; irq_enable = 4'b1000;
      send(SYS, 3'b000, 12'h000, 5'd0, ex_t(32'h8000_0006, PM));
      irq_pending = 4'b0000; irq_enable = 4'b0000;
      pulse_trap();

      // back to S, then hold a bundle under backpressure and reset mid-hold
      mstatus = 32'h0000_0800;
      send(SYS, 3'b000, 12'h302, 5'd0, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      pulse_xret();
      check("priv_s_before_hold", 64'(current_privilege), 64'(PS));
      out_ready = 1'b0;
      send(SYS, 3'b010, 12'hC00, 5'd0, mk(1'b1, 3'b010, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("hold_valid", 64'(out_valid), 64'd1);
         check("hold_fields", 64'({is_csr, csr_op, exception_valid}), 64'({1'b1, 3'b010, 1'b0}));
         check("hold_ready", 64'(in_ready), 64'd0);
      end
      #2 rst = 1'b0;
      #1;
      check("async_rst_valid", 64'(out_valid), 64'd0);
      check("async_rst_priv", 64'(current_privilege), 64'(PM));
      check("async_rst_flags", 64'({is_csr, csr_op}), 64'd0);
      sb.delete();
      out_ready = 1'b1;
      @(negedge clk) rst = 1'b1;

      // HAS_S_MODE=0 instance alongside the full one
      mstatus = 32'h0000_0000;
      medeleg = 32'hFFFF_FFFF;
      send(SYS, 3'b000, 12'h102, 5'd0, mk(1'b0, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 32'd0, PM));
      check("ns_sret_exc", 64'({ns_exc, ns_is_sret}), 64'({1'b1, 1'b0}));
      check("ns_sret_cause", 64'(ns_cause), 64'd2);
      check("ns_sret_target", 64'(ns_target), 64'(PM));
      pulse_trap();
      check("main_priv_m", 64'(current_privilege), 64'(PM));
      check("ns_priv_m", 64'(ns_priv), 64'(PM));
      send(SYS, 3'b000, 12'h302, 5'd0, mk(1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, PM));
      pulse_xret();
      check("main_priv_u", 64'(current_privilege), 64'(PU));
      check("ns_priv_u", 64'(ns_priv), 64'(PU));
      send(SYS, 3'b000, 12'h000, 5'd0, ex_t(32'd8, PS));
      check("ns_ecall_cause", 64'(ns_cause), 64'd8);
      check("ns_ecall_target", 64'(ns_target), 64'(PM));
      pulse_trap();
      check("main_priv_deleg", 64'(current_privilege), 64'(PS));
      check("ns_priv_nodeleg", 64'(ns_priv), 64'(PM));

      repeat (3) @(negedge clk);
      check("scoreboard_drained", 64'(sb.size()), 64'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
